// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - shared constants, FSM encoding and helpers for the centroid tracker
package track_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ACC_W_DEF    = 32;
    localparam int CNT_W_DEF    = 20;
    localparam int IIR_SHIFT    = 2;

    typedef logic [1:0] track_state_t;
    localparam track_state_t IDLE   = 2'd0;
    localparam track_state_t DIV_X  = 2'd1;
    localparam track_state_t DIV_Y  = 2'd2;
    localparam track_state_t UPDATE = 2'd3;

    // Saturating increment used by the persistence counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/target_centroid_tracker_if.sv
// rtl/target_centroid_tracker_if.sv - camera mask stream in, servo coordinate out
interface target_centroid_tracker_if;
    logic        vsync_in;
    logic        href_in;
    logic        pix_valid;
    logic        pix_hit;
    logic [11:0] x;
    logic [10:0] y;
    logic        Move_EN;
    logic        coord_valid;
    logic        frame_drop;

    modport master (
        output vsync_in, href_in, pix_valid, pix_hit,
        input  x, y, Move_EN, coord_valid, frame_drop
    );

    modport slave (
        input  vsync_in, href_in, pix_valid, pix_hit,
        output x, y, Move_EN, coord_valid, frame_drop
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle, start/busy/done
module seq_divider
    import track_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [ACC_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] quotient_o
);
    localparam int STEP_W = $clog2(ACC_W) + 1;

    logic [CNT_W-1:0]  rem_q, rem_d, div_q, src_rem, src_div;
    logic [ACC_W-1:0]  quo_q, quo_d, src_quo;
    logic [CNT_W:0]    shifted, trial;
    logic [STEP_W-1:0] step_q;
    logic              busy_q, done_q;

    // One restoring step; on start the step runs directly on the new operands.
    // The remainder is always below the divisor, so trial's MSB is the borrow.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_div = start_i ? divisor_i : div_q;
        shifted = {src_rem, src_quo[ACC_W-1]};
        trial   = shifted - {1'b0, src_div};
        quo_d   = {src_quo[ACC_W-2:0], ~trial[CNT_W]};
        rem_d   = trial[CNT_W] ? shifted[CNT_W-1:0] : trial[CNT_W-1:0];
    end

    // Iteration counter and datapath registers; done pulses after the last bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                div_q  <= divisor_i;
                step_q <= STEP_W'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                step_q <= step_q + STEP_W'(1);
                if (step_q == STEP_W'(ACC_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;
endmodule

// File: rtl/target_centroid_tracker.sv
// rtl/target_centroid_tracker.sv - per-frame mask centroid with acquire/lose hysteresis; optional CENTROID_IIR_EN smoothing
module target_centroid_tracker
    import track_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_PIXELS  = 64,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 8
) (
    input  logic                       clk_50M,
    input  logic                       reset,
    target_centroid_tracker_if.slave   bus
);
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    logic             vsync_q, href_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q, row_eff;
    logic [ACC_W-1:0] sum_x_q, sum_y_q, snap_x_q, snap_y_q, qx_q, div_quo, div_dividend;
    logic [CNT_W-1:0] cnt_q, snap_cnt_q;
    logic             snap_new_q, meas_seen_q, frame_drop_q;
    track_state_t     state_q, state_d;
    logic             div_start, div_busy, div_done;
    logic             vsync_rise, href_fall, pix_take, hit, snap_seen;
    logic [11:0]      x_q, meas_x, x_next;
    logic [10:0]      y_q, meas_y, y_next;
    logic             move_en_q, coord_valid_q;
    logic [7:0]       seen_cnt_q, lost_cnt_q, seen_inc, lost_inc;

    assign vsync_rise = bus.vsync_in & ~vsync_q;
    assign href_fall  = ~bus.href_in & href_q;
    assign pix_take   = bus.pix_valid & bus.href_in;
    assign row_eff    = vsync_rise ? '0 : row_q;
    assign hit        = pix_take & bus.pix_hit & (col_q < COL_W'(H_ACTIVE)) & (row_eff < ROW_W'(V_ACTIVE));
    assign snap_seen  = (snap_cnt_q >= CNT_W'(MIN_PIXELS)) && (snap_cnt_q != '0);

    // Edge detectors plus saturating column/row position of the incoming pixel.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            vsync_q <= bus.vsync_in;
            href_q  <= bus.href_in;
            if (href_fall)
                col_q <= '0;
            else if (pix_take && col_q != COL_W'(H_ACTIVE))
                col_q <= col_q + COL_W'(1);
            if (vsync_rise)
                row_q <= '0;
            else if (href_fall && row_q != ROW_W'(V_ACTIVE))
                row_q <= row_q + ROW_W'(1);
        end
    end

    // Live accumulators; a frame boundary restarts them with the pixel of that cycle.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
        end else if (vsync_rise) begin
            sum_x_q <= hit ? ACC_W'(col_q) : '0;
            sum_y_q <= '0;
            cnt_q   <= hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            sum_x_q <= sum_x_q + ACC_W'(col_q);
            sum_y_q <= sum_y_q + ACC_W'(row_eff);
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Shadow copy of the finished frame, or a drop pulse when still computing.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_cnt_q   <= '0;
            snap_new_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            snap_new_q   <= 1'b0;
            frame_drop_q <= vsync_rise && (state_q != IDLE || div_busy);
            if (vsync_rise && state_q == IDLE && !div_busy) begin
                snap_x_q   <= sum_x_q;
                snap_y_q   <= sum_y_q;
                snap_cnt_q <= cnt_q;
                snap_new_q <= 1'b1;
            end
        end
    end

    // Sequencing: divide X, then Y on the same divider, then publish.
    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_dividend = snap_x_q;
        case (state_q)
            IDLE: if (snap_new_q) begin
                if (snap_seen) begin
                    state_d   = DIV_X;
                    div_start = 1'b1;
                end else begin
                    state_d = UPDATE;
                end
            end
            DIV_X: if (div_done) begin
                state_d      = DIV_Y;
                div_start    = 1'b1;
                div_dividend = snap_y_q;
            end
            DIV_Y: if (div_done) state_d = UPDATE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, seen flag of the frame in flight and the captured X quotient.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q     <= IDLE;
            meas_seen_q <= 1'b0;
            qx_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && snap_new_q)
                meas_seen_q <= snap_seen;
            if (state_q == DIV_X && div_done)
                qx_q <= div_quo;
        end
    end

    seq_divider #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_div (
        .clk_i      (clk_50M),
        .reset_i    (reset),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (snap_cnt_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Clamped measurement and the value x/y take on a seen frame.
    always_comb begin
        meas_x   = (qx_q >= ACC_W'(H_ACTIVE)) ? 12'(H_ACTIVE - 1) : qx_q[11:0];
        meas_y   = (div_quo >= ACC_W'(V_ACTIVE)) ? 11'(V_ACTIVE - 1) : div_quo[10:0];
        seen_inc = sat_inc8(seen_cnt_q);
        lost_inc = sat_inc8(lost_cnt_q);
`ifdef CENTROID_IIR_EN
        x_next = move_en_q ? x_q + 12'(($signed({1'b0, meas_x}) - $signed({1'b0, x_q})) >>> IIR_SHIFT) : meas_x;
        y_next = move_en_q ? y_q + 11'(($signed({1'b0, meas_y}) - $signed({1'b0, y_q})) >>> IIR_SHIFT) : meas_y;
`else
        x_next = meas_x;
        y_next = meas_y;
`endif
    end

    // Output registers and persistence hysteresis, touched only in UPDATE.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            x_q           <= 12'(H_ACTIVE / 2);
            y_q           <= 11'(V_ACTIVE / 2);
            move_en_q     <= 1'b0;
            coord_valid_q <= 1'b0;
            seen_cnt_q    <= '0;
            lost_cnt_q    <= '0;
        end else begin
            coord_valid_q <= 1'b0;
            if (state_q == UPDATE) begin
                coord_valid_q <= 1'b1;
                if (meas_seen_q) begin
                    x_q        <= x_next;
                    y_q        <= y_next;
                    seen_cnt_q <= seen_inc;
                    lost_cnt_q <= '0;
                    if (seen_inc >= 8'(ACQ_FRAMES)) move_en_q <= 1'b1;
                end else begin
                    seen_cnt_q <= '0;
                    lost_cnt_q <= lost_inc;
                    if (lost_inc >= 8'(LOST_FRAMES)) move_en_q <= 1'b0;
                end
            end
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.Move_EN     = move_en_q;
    assign bus.coord_valid = coord_valid_q;
    assign bus.frame_drop  = frame_drop_q;
endmodule

// File: tb/tb_target_centroid_tracker.sv
// tb/tb_target_centroid_tracker.sv - randomized frames against a frame-level centroid model
module tb_target_centroid_tracker;
    import track_pkg::*;

    localparam int H = 64, V = 24, MINP = 16, ACQ = 3, LOST = 8, ACCW = 32;
    localparam int LAT_SEEN = 2 * ACCW + 2, LAT_UNSEEN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    target_centroid_tracker_if bus();

    target_centroid_tracker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ACC_W(ACCW), .CNT_W(20),
        .MIN_PIXELS(MINP), .ACQ_FRAMES(ACQ), .LOST_FRAMES(LOST)
    ) dut (
        .clk_50M (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    int n_checks = 0, n_fail = 0;
    int m_x, m_y, m_seen, m_lost;
    bit m_move;
    int sx, sy, cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = H / 2; m_y = V / 2; m_seen = 0; m_lost = 0; m_move = 0;
    endtask

    // Frame-end rule: mean of in-range hits, then acquire/lose hysteresis.
    task automatic model_frame_end(output bit seen);
        int mx, my, d;
        seen = (cnt >= MINP) && (cnt > 0);
        if (seen) begin
            mx = sx / cnt; if (mx > H - 1) mx = H - 1;
            my = sy / cnt; if (my > V - 1) my = V - 1;
`ifdef CENTROID_IIR_EN
            if (m_move) begin
                d = mx - m_x; m_x = m_x + (d >>> 2);
                d = my - m_y; m_y = m_y + (d >>> 2);
            end else begin
                m_x = mx; m_y = my;
            end
`else
            d = 0;
            m_x = mx + d; m_y = my;
`endif
            m_seen = (m_seen < 255) ? m_seen + 1 : 255;
            m_lost = 0;
            if (m_seen >= ACQ) m_move = 1;
        end else begin
            m_seen = 0;
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
            if (m_lost >= LOST) m_move = 0;
        end
    endtask

    // Lines of pixels; hits inside [x0..x1]x[y0..y1] with probability pct.
    task automatic drive_frame(input int lines, input int ppl, input int x0, input int x1,
                               input int y0, input int y1, input int pct);
        bit h;
        sx = 0; sy = 0; cnt = 0;
        for (int r = 0; r < lines; r++) begin
            bus.href_in = 1'b1;
            for (int c = 0; c < ppl; c++) begin
                if ($urandom_range(3) == 0) begin
                    bus.pix_valid = 1'b0;
                    tick();
                end
                h = (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1) && ($urandom_range(99) < pct);
                bus.pix_valid = 1'b1;
                bus.pix_hit   = h;
                tick();
                if (h && c < H && r < V) begin
                    sx += c; sy += r; cnt++;
                end
            end
            bus.pix_valid = 1'b0;
            bus.pix_hit   = 1'b0;
            bus.href_in   = 1'b0;
            tick();
            tick();
        end
    endtask

    // Raise vsync and watch the published result; drop_at>0 injects a second edge.
    task automatic close_frame(input string tag, input int drop_at);
        bit seen;
        int first, n_cv, n_drop, ox, oy, om;
        model_frame_end(seen);
        first = -1; n_cv = 0; n_drop = 0; ox = 0; oy = 0; om = 0;
        bus.vsync_in = 1'b1;
        tick();
        bus.vsync_in = 1'b0;
        if (bus.frame_drop) n_drop++;
        for (int t = 1; t <= LAT_SEEN + 8; t++) begin
            if (drop_at > 0 && t == drop_at) bus.vsync_in = 1'b1;
            if (drop_at > 0 && t == drop_at + 1) bus.vsync_in = 1'b0;
            tick();
            if (bus.frame_drop) n_drop++;
            if (bus.coord_valid) begin
                n_cv++;
                if (first < 0) begin
                    first = t; ox = bus.x; oy = bus.y; om = bus.Move_EN;
                end
            end
        end
        check({tag, " latency"}, first, seen ? LAT_SEEN : LAT_UNSEEN);
        check({tag, " cv_count"}, n_cv, 1);
        check({tag, " drops"}, n_drop, (drop_at > 0) ? 1 : 0);
        check({tag, " x"}, ox, m_x);
        check({tag, " y"}, oy, m_y);
        check({tag, " move_en"}, om, m_move);
    endtask

    initial begin
        int n_cv;
        bus.vsync_in = 1'b0; bus.href_in = 1'b0; bus.pix_valid = 1'b0; bus.pix_hit = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset x", bus.x, H / 2);
        check("reset y", bus.y, V / 2);
        check("reset move_en", bus.Move_EN, 0);
        check("reset coord_valid", bus.coord_valid, 0);
        check("reset frame_drop", bus.frame_drop, 0);
        rst = 1'b0;
        tick();

        drive_frame(6, 12, 10, 10, 5, 5, 100);
        close_frame("single_hit", 0);

        for (int f = 0; f < 3; f++) begin
            drive_frame(16, 32, 20, 29, 4, 13, 100);
            close_frame($sformatf("block%0d", f), 0);
        end

        for (int f = 0; f < 8; f++) begin
            drive_frame(4, 8, 0, 0, 0, 0, 0);
            close_frame($sformatf("empty%0d", f), 0);
        end

        drive_frame(16, 32, 20, 29, 4, 13, 100);
        close_frame("drop", 20);

        drive_frame(16, 32, 20, 29, 4, 13, 100);
        bus.vsync_in = 1'b1;
        tick();
        bus.vsync_in = 1'b0;
        repeat (31) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("midreset x", bus.x, H / 2);
        check("midreset y", bus.y, V / 2);
        check("midreset move_en", bus.Move_EN, 0);
        check("midreset coord_valid", bus.coord_valid, 0);
        n_cv = 0;
        for (int t = 0; t < LAT_SEEN + 8; t++) begin
            tick();
            if (bus.coord_valid) n_cv++;
        end
        check("midreset no_cv", n_cv, 0);

        for (int f = 0; f < 25; f++) begin
            int x0, y0, pct;
            int pcts[4] = '{0, 5, 60, 100};
            x0  = $urandom_range(0, H + 2);
            y0  = $urandom_range(0, V + 1);
            pct = pcts[$urandom_range(3)];
            drive_frame($urandom_range(2, V + 3), $urandom_range(4, H + 6),
                        x0, x0 + $urandom_range(0, 30), y0, y0 + $urandom_range(0, 12), pct);
            close_frame($sformatf("rand%0d", f), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
